regfile_dump_reader: RTL and testbench
======================================

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle dump request.
REQ-006 SHALL have port abort  input  1  cancel dump in progress.
REQ-007 SHALL have port first_reg  input  ADDR_W  first register index, sampled on accepted start.
REQ-008 SHALL have port last_reg  input  ADDR_W  last register index, sampled on accepted start.
REQ-009 SHALL have port rf_addr  output  ADDR_W  register-file read address (drives rs1/rs2-style read port).
REQ-010 SHALL have port rf_data  input  DATA_W  combinational read data for rf_addr.
REQ-011 SHALL have port out_valid  output  1  beat valid.
REQ-012 SHALL have port out_ready  input  1  sink accepts beat.
REQ-013 SHALL have port out_data  output  DATA_W  register value.
REQ-014 SHALL have port out_index  output  ADDR_W  register index of beat.
REQ-015 SHALL have port out_last  output  1  beat is final of dump.
REQ-016 SHALL have ports busy  output  1  and done  output  1 (one-cycle pulse) and err  output  1 (valid with done).

Function
REQ-017 SHALL implement FSM states IDLE, READ, SEND, DONE.
REQ-018 IDLE: start=1 with first_reg<=last_reg SHALL latch range, set index=first_reg, go READ.
REQ-019 IDLE: start=1 with first_reg>last_reg SHALL go DONE with err=1, emitting no beats.
REQ-020 rf_addr SHALL equal current index in all states; 0 in IDLE.
REQ-021 READ: SHALL register rf_data into out_data, index into out_index, out_last=(index==last), go SEND; exactly one cycle.
REQ-022 Index 0 SHALL always report out_data=0 regardless of rf_data (x0 never written, contents undefined).
REQ-023 SEND: out_valid=1; out_data/out_index/out_last SHALL stay stable until out_valid&&out_ready.
REQ-024 SEND handshake with out_last=0 SHALL increment index and go READ; with out_last=1 SHALL go DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; err SHALL be 0 unless set by REQ-019 or REQ-027.
REQ-026 start SHALL be ignored whenever state!=IDLE; busy=1 in READ, SEND, DONE.
REQ-027 abort=1 in READ or SEND SHALL drop out_valid next cycle, go DONE with err=1; abort has priority over handshake; abort in IDLE/DONE SHALL be ignored.
REQ-028 Latency start to first out_valid SHALL be 2 cycles; throughput SHALL be one beat per 2 cycles with out_ready held 1.
REQ-029 Index SHALL NOT wrap: last_reg=31 terminates at 31; first_reg==last_reg SHALL yield one beat with out_last=1.
REQ-030 Block SHALL be read-only toward the register file; no write-side signals.

Reset
REQ-031 rst=1 SHALL force IDLE asynchronously, mid-dump included, with out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, err=0, rf_addr=0, latched range=0.
REQ-032 After rst release, the first start SHALL be honoured on the first rising edge.

Structure
REQ-033 FSM state encodings and the DATA_W/ADDR_W defaults SHALL reside in the shared rv32i constants package/include.
REQ-034 Implementation SHALL be a single module, no sub-modules; the register file remains external.

Verification
REQ-035 first=1,last=3, out_ready=1, rf returns 0x100+idx -> beats (1,0x101),(2,0x102),(3,0x103,last); done cycle 8 after start.
REQ-036 first=0,last=0, rf_data=0xDEADBEEF -> one beat index 0, data 0, out_last=1, err=0.
REQ-037 first=5,last=2 -> no out_valid, done=1 err=1 two cycles after start.
REQ-038 first=30,last=31, out_ready low 3 cycles on first beat -> data/index stable while stalled, no wrap past 31.
REQ-039 abort during SEND of index 4 in 0..7 dump -> out_valid=0 next cycle, done=1 err=1, then IDLE; start while busy ignored.
REQ-040 rst asserted mid-SEND -> all outputs 0 immediately without clock edge; new start then dumps normally.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants for the register-file dump reader: default widths and FSM states.
package regfile_dump_reader_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register index range through an external register-file read port and
// streams each value out as a ready/valid beat; x0 always reads as zero.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] last_q;
  logic              err_q;
  logic              range_ok;

  assign range_ok = (first_reg <= last_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = range_ok ? ST_READ : ST_DONE;
      ST_READ: state_nxt = abort ? ST_DONE : ST_SEND;
      ST_SEND: begin
        // abort wins over a same-cycle handshake
        if (abort)          state_nxt = ST_DONE;
        else if (out_ready) state_nxt = out_last ? ST_DONE : ST_READ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_SEND);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    err       = (state == ST_DONE) && err_q;
    rf_addr   = (state == ST_IDLE) ? '0 : idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      last_q    <= '0;
      err_q     <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_q <= !range_ok;
            if (range_ok) begin
              idx_q  <= first_reg;
              last_q <= last_reg;
            end
          end
        end
        ST_READ: begin
          if (abort) begin
            err_q <= 1'b1;
          end else begin
            out_data  <= (idx_q == '0) ? '0 : rf_data;
            out_index <= idx_q;
            out_last  <= (idx_q == last_q);
          end
        end
        ST_SEND: begin
          if (abort)                       err_q <= 1'b1;
          else if (out_ready && !out_last) idx_q <= idx_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a beat-list reference model.
module tb_regfile_dump_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int INF = 1000000;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, out_ready;
  logic [AW-1:0] first_reg, last_reg, rf_addr, out_index;
  logic [DW-1:0] rf_data, out_data;
  logic          out_valid, out_last, busy, done, err;
  logic [31:0]   mem [32];

  int total = 0;
  int bad   = 0;
  int done_at;

  always #5 clk = ~clk;

  assign rf_data = mem[rf_addr];

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data,  0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_last"},  out_last,  0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_err"},   err,       0);
    check({tag, "_addr"},  rf_addr,   0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
  endtask

  // Called just after a falling edge; the start request goes out in this cycle (cycle 1).
  task automatic do_dump(input int f, input int l, input int stall_pct, input int stall_first,
                         input int abort_beat, input bit abort_read, output int finish_cyc);
    beat_t q[$];
    int    k = 0, cyc = 1, next_v, done_cyc, stalls = 0;
    bit    ended = 0, exp_err, exp_v, rdy;
    q.delete();
    if (f <= l) begin
      for (int i = f; i <= l; i++) q.push_back('{i, (i == 0) ? 32'h0 : mem[i], i == l});
      next_v = 3; done_cyc = INF; exp_err = 0;
    end else begin
      next_v = INF; done_cyc = 2; exp_err = 1;
    end
    finish_cyc = -1;
    start = 1; first_reg = AW'(f); last_reg = AW'(l); abort = 0;
    out_ready = 1'($urandom_range(0, 1));
    while (!ended) begin
      @(negedge clk);
      cyc++;
      start = 1'($urandom_range(0, 1)); first_reg = AW'($urandom); last_reg = AW'($urandom);
      abort = 0;
      exp_v = (cyc >= next_v);
      check("busy", busy, 1);
      check("valid", out_valid, exp_v);
      check("done", done, cyc == done_cyc);
      if (exp_v && out_valid) begin
        check("index", out_index, q[k].idx);
        check("data",  out_data,  q[k].data);
        check("last",  out_last,  q[k].last);
        check("rf_addr", rf_addr, q[k].idx);
      end
      if (cyc == done_cyc) begin
        check("err", err, exp_err);
        start = 0;
        abort = 1'($urandom_range(0, 1));
        finish_cyc = cyc;
        ended = 1;
      end else if (cyc > 400) begin
        check("timeout", cyc, 0);
        ended = 1;
      end else if (exp_v) begin
        rdy = (k == 0 && stalls < stall_first) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
        if (k == 0 && !rdy) stalls++;
        out_ready = rdy;
        if (k == abort_beat && !abort_read) begin
          abort = 1; next_v = INF; done_cyc = cyc + 1; exp_err = 1;
        end else if (rdy) begin
          k++;
          if (k == q.size()) begin next_v = INF; done_cyc = cyc + 1; end
          else next_v = cyc + 2;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        if (abort_read && k == abort_beat && cyc == next_v - 1) begin
          abort = 1; next_v = INF; done_cyc = cyc + 1; exp_err = 1;
        end
      end
    end
    @(negedge clk);
    check("idle_busy",  busy,      0);
    check("idle_valid", out_valid, 0);
    check("idle_done",  done,      0);
    check("idle_err",   err,       0);
    check("idle_addr",  rf_addr,   0);
    abort = 0; start = 0;
  endtask

  initial begin
    int f, l, t, ab;
    rst = 1; start = 0; abort = 0; out_ready = 0; first_reg = '0; last_reg = '0;
    randomize_mem();
    @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    do_dump(1, 3, 0, 0, -1, 0, done_at);
    check("seq_done_cyc", done_at, 8);

    mem[0] = 32'hDEADBEEF;
    do_dump(0, 0, 0, 0, -1, 0, done_at);
    check("x0_done_cyc", done_at, 4);

    do_dump(5, 2, 0, 0, -1, 0, done_at);
    check("bad_range_done_cyc", done_at, 2);

    randomize_mem();
    do_dump(30, 31, 0, 3, -1, 0, done_at);
    check("stall_done_cyc", done_at, 9);

    randomize_mem();
    do_dump(0, 7, 0, 0, 4, 0, done_at);
    check("abort_send_done_cyc", done_at, 12);

    do_dump(10, 20, 20, 0, 2, 1, done_at);

    // asynchronous reset while a beat is stalled in SEND
    start = 1; first_reg = 5'd2; last_reg = 5'd6; out_ready = 0;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 0;
    randomize_mem();
    do_dump(2, 6, 30, 0, -1, 0, done_at);

    for (int n = 0; n < 40; n++) begin
      randomize_mem();
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      if (f > l && $urandom_range(0, 3) != 0) begin t = f; f = l; l = t; end
      ab = ($urandom_range(0, 3) == 0 && f <= l) ? $urandom_range(0, l - f) : -1;
      do_dump(f, l, $urandom_range(0, 70), $urandom_range(0, 2), ab,
              1'($urandom_range(0, 1)), done_at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
